seq_scan_ctrl: RTL

- Controller that takes a parallel data word, serialises it MSB-first into an embedded programmable Moore pattern detector, and counts pattern hits.
- Reports completion with a start/busy/done handshake.
- Sits between a register/host interface and the serial sequence-detector datapath; sequences the detector for one word per request.

---
 rtl/seq_scan_pkg.sv | 6 +
 rtl/seq_pat_det.sv | 38 +++
 rtl/seq_scan_ctrl.sv | 96 +++++++++
 3 files changed

// File: rtl/seq_scan_pkg.sv
// seq_scan_pkg: shared state encoding and default pattern for the serial scan controller.
package seq_scan_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, FLUSH, DONE} state_t;
  localparam int DEF_PAT_W = 5;
  localparam logic [DEF_PAT_W-1:0] DEF_PATTERN = 5'b10110;
endpackage

// File: rtl/seq_pat_det.sv
// seq_pat_det: programmable Moore pattern detector with fill tracking.
// Ports: clk, rst (sync, active high), en (sample in_seq this edge), in_seq (serial bit),
//        overlap_en (1 = overlapping hits), clr (sync clear of window/fill/output),
//        det_out (registered, high the cycle after the completing bit is sampled).
module seq_pat_det import seq_scan_pkg::*; #(
  parameter int PAT_W = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN)
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic in_seq,
  input  logic overlap_en,
  input  logic clr,
  output logic det_out
);
  localparam int FILL_W = $clog2(PAT_W + 1);
  logic [PAT_W-1:0] win, win_nx;
  logic [FILL_W-1:0] fill, fill_nx;
  logic hit_nx;
  always_comb begin
    win_nx = {win[PAT_W-2:0], in_seq};
    fill_nx = fill == FILL_W'(PAT_W) ? fill : fill + 1'b1;
    hit_nx = win_nx == PATTERN && fill_nx == FILL_W'(PAT_W);
  end
  // A hit is decided on the incoming window so det_out lands exactly one cycle after the bit.
  always_ff @(posedge clk)
    if (rst || clr) begin
      win <= '0;
      fill <= '0;
      det_out <= 1'b0;
    end else if (en) begin
      win <= win_nx;
      fill <= hit_nx && !overlap_en ? '0 : fill_nx;
      det_out <= hit_nx;
    end else
      det_out <= 1'b0;
endmodule

// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl: serialises a word MSB-first into a Moore pattern detector and counts hits.
// Ports: clk, rst (sync, active high), start, data_in[DATA_W], overlap_en -> ser_out, busy,
//        done (1-cycle pulse), det_pulse, det_count[CNT_W] (saturating, held until next start).
// Optional macro SEQ_SCAN_FIRST_POS_EN adds first_pos[$clog2(DATA_W)] and first_vld.
module seq_scan_ctrl import seq_scan_pkg::*; #(
  parameter int DATA_W = 16,
  parameter int PAT_W = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN),
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic [DATA_W-1:0] data_in,
  input  logic overlap_en,
  output logic ser_out,
  output logic busy,
  output logic done,
  output logic det_pulse,
  output logic [CNT_W-1:0] det_count
`ifdef SEQ_SCAN_FIRST_POS_EN
  ,
  output logic [$clog2(DATA_W)-1:0] first_pos,
  output logic first_vld
`endif
);
  localparam int IDX_W = $clog2(DATA_W);
  state_t state;
  logic [DATA_W-1:0] sh;
  logic [IDX_W-1:0] idx;
  logic ov, clr;
  assign clr = state == IDLE && start;
  seq_pat_det #(.PAT_W(PAT_W), .PATTERN(PATTERN)) u_det (
    .clk(clk), .rst(rst), .en(state == SHIFT), .in_seq(ser_out),
    .overlap_en(ov), .clr(clr), .det_out(det_pulse)
  );
  // ser_out is registered: the MSB is loaded on acceptance so bit k is on the wire in SHIFT cycle k.
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      sh <= '0;
      idx <= '0;
      ov <= 1'b0;
      ser_out <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      det_count <= '0;
    end else begin
      done <= 1'b0;
      if (det_pulse && det_count != '1) det_count <= det_count + 1'b1;
      case (state)
        IDLE: if (start) begin
          state <= SHIFT;
          sh <= {data_in[DATA_W-2:0], 1'b0};
          ser_out <= data_in[DATA_W-1];
          idx <= '0;
          ov <= overlap_en;
          busy <= 1'b1;
          det_count <= '0;
        end
        SHIFT: if (idx == IDX_W'(DATA_W - 1)) begin
          state <= FLUSH;
          ser_out <= 1'b0;
        end else begin
          ser_out <= sh[DATA_W-1];
          sh <= sh << 1;
          idx <= idx + 1'b1;
        end
        FLUSH: begin
          state <= DONE;
          busy <= 1'b0;
          done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
`ifdef SEQ_SCAN_FIRST_POS_EN
  // det_pulse trails the sampled bit by one cycle, so remember the index that was just sampled.
  logic [IDX_W-1:0] prev_idx;
  always_ff @(posedge clk)
    if (rst) begin
      prev_idx <= '0;
      first_pos <= '0;
      first_vld <= 1'b0;
    end else begin
      if (state == SHIFT) prev_idx <= idx;
      if (clr) begin
        first_pos <= '0;
        first_vld <= 1'b0;
      end else if (det_pulse && !first_vld) begin
        first_pos <= prev_idx;
        first_vld <= 1'b1;
      end
    end
`endif
endmodule
